// File: rtl/draw_rect_ctl.sv
// Rectangle motion controller: follows the mouse in idle, falls under gravity after a click,
// bounces off the floor with damping and comes to rest.
module draw_rect_ctl #(
   parameter int unsigned TICK_DIV    = 650_000,
   parameter int unsigned VER_PIXELS  = 768,
   parameter int unsigned RECT_HEIGHT = 64,
   parameter int unsigned G           = 1,
   parameter int unsigned MIN_V       = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   output logic [11:0] xpos,
   output logic [11:0] ypos
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [11:0] FLOOR = 12'(VER_PIXELS - RECT_HEIGHT);
   localparam logic [11:0] G_V   = 12'(G);
   localparam logic [12:0] MIN_W = 13'(MIN_V);

   typedef enum logic [1:0] {StIdle, StFall, StRise, StRest} state_e;

   state_e           state;
   logic [11:0]      v;
   logic [CNT_W-1:0] cnt;
   logic             left_d;

   logic        click;
   logic        moving;
   logic        tick;
   logic [11:0] y_clamp;
   logic [12:0] fall_v_n;
   logic [12:0] fall_y_n;
   logic [12:0] fall_v_b;
   logic        fall_hit;
   logic        fall_rest;
   logic [11:0] rise_v_n;
   logic        rise_under;

   always_comb begin
      click      = mouse_left & ~left_d;
      moving     = (state == StFall) || (state == StRise);
      tick       = moving && (cnt == CNT_MAX);
      y_clamp    = (mouse_ypos > FLOOR) ? FLOOR : mouse_ypos;
      // Fall arithmetic is one bit wider so a fast drop past the floor cannot wrap.
      fall_v_n   = {1'b0, v} + {1'b0, G_V};
      fall_y_n   = {1'b0, ypos} + fall_v_n;
      fall_hit   = fall_y_n >= {1'b0, FLOOR};
      fall_v_b   = fall_v_n - (fall_v_n >> 2);
      fall_rest  = fall_v_b < MIN_W;
      rise_v_n   = (v > G_V) ? (v - G_V) : 12'd0;
      rise_under = ypos < rise_v_n;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= StIdle;
         xpos   <= 12'd0;
         ypos   <= 12'd0;
         v      <= 12'd0;
         cnt    <= '0;
         left_d <= 1'b0;
      end else begin
         left_d <= mouse_left;

         if (moving) begin
            cnt <= tick ? '0 : cnt + 1'b1;
         end else begin
            cnt <= '0;
         end

         unique case (state)
            StIdle: begin
               if (click) begin
                  v     <= 12'd0;
                  state <= StFall;
               end else begin
                  xpos <= mouse_xpos;
                  ypos <= y_clamp;
               end
            end
            StFall: begin
               if (tick) begin
                  if (fall_hit) begin
                     ypos <= FLOOR;
                     if (fall_rest) begin
                        v     <= 12'd0;
                        state <= StRest;
                     end else begin
                        v     <= fall_v_b[11:0];
                        state <= StRise;
                     end
                  end else begin
                     ypos <= fall_y_n[11:0];
                     v    <= fall_v_n[11:0];
                  end
               end
            end
            StRise: begin
               if (tick) begin
                  if (rise_v_n == 12'd0) begin
                     v     <= 12'd0;
                     state <= StFall;
                  end else if (rise_under) begin
                     ypos  <= 12'd0;
                     v     <= 12'd0;
                     state <= StFall;
                  end else begin
                     ypos <= ypos - rise_v_n;
                     v    <= rise_v_n;
                  end
               end
            end
            StRest: begin
               if (click) begin
                  state <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/draw_rect_ctl.md
# draw_rect_ctl

Motion controller placed upstream of `draw_rect`. It generates `xpos`/`ypos` for the rectangle. In IDLE the rectangle follows the mouse position from `MouseCtl`. A left click releases it: the rectangle falls under constant gravity, bounces off the screen bottom with damping, and comes to rest. All outputs are registered and driven in the `clk` (pixel clock) domain.

## Interface
Parameters:
- `TICK_DIV`, default 650_000: clk cycles per motion tick (100 Hz at 65 MHz).
- `VER_PIXELS`, default 768: visible screen height.
- `RECT_HEIGHT`, default 64: rectangle height; floor is `FLOOR = VER_PIXELS - RECT_HEIGHT` (704).
- `G`, default 1: velocity increment per tick (pixels/tick²).
- `MIN_V`, default 2: bounce velocity below which the rectangle rests.

Ports:
- `clk`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: reset, synchronous, active-low.
- `mouse_xpos`, in, 12: mouse X, already in the clk domain.
- `mouse_ypos`, in, 12: mouse Y, already in the clk domain.
- `mouse_left`, in, 1: left button level, already synchronised to clk.
- `xpos`, out, 12: rectangle X for `draw_rect`.
- `ypos`, out, 12: rectangle Y for `draw_rect`.

## Operation
- Reset (`rst`=0 at a clk edge):
  - state←IDLE.
  - `xpos`, `ypos`, velocity `v` (12-bit unsigned), tick counter, `left_d` all ←0.
- Click detection: `left_d` registers `mouse_left`. A click is `mouse_left & ~left_d`.
- Tick: counter runs 0..TICK_DIV-1 while state ∈ {FALL, RISE}. `tick`=1 in the cycle the counter equals TICK_DIV-1, then the counter wraps to 0. The counter is held at 0 in IDLE and REST.
- IDLE:
  - Each cycle `xpos`←`mouse_xpos` and `ypos`←min(`mouse_ypos`, FLOOR).
  - On click: `v`←0, state←FALL. `xpos`/`ypos` freeze at their current registered values; the click-cycle mouse sample is not loaded.
- FALL: on tick, `v_n`=`v`+G and `y_n`=`ypos`+`v_n`, computed 13 bits wide.
  - If `y_n` ≥ FLOOR: `ypos`←FLOOR and `v_b`=`v_n`−(`v_n`>>2). If `v_b` < MIN_V, then `v`←0 and state←REST; otherwise `v`←`v_b` and state←RISE.
  - Otherwise: `ypos`←`y_n`, `v`←`v_n`.
- RISE: on tick, `v_n`=`v`−G with saturation at 0.
  - If `v_n`=0: state←FALL, `v`←0, `ypos` unchanged.
  - Else if `ypos` < `v_n`: `ypos`←0, `v`←0, state←FALL.
  - Else: `ypos`←`ypos`−`v_n`, `v`←`v_n`.
- REST: outputs hold. A click returns the block to IDLE, and mouse following resumes the next cycle.
- Clicks during FALL/RISE are ignored. `left_d` still updates.
- `xpos` is constant throughout FALL/RISE/REST.
- Velocity never exceeds 12 bits (max fall speed < 2·√FLOOR ≈ 53).

## Timing
- IDLE follow latency: one clk. A `mouse_*` change at edge k appears on `xpos`/`ypos` after edge k+1.
- Click latency: the edge is detected in the cycle `mouse_left` is first seen high, and the state changes at that clock edge.
- Counter: starts at 0 in the first FALL cycle, so the first motion update occurs TICK_DIV cycles after entering FALL. Subsequent updates follow every TICK_DIV cycles, continuous across FALL↔RISE transitions (the counter is not reset there).
- All outputs change only on clk rising edges. There is no combinational path from input to output.
- Reset asserted mid-FALL/RISE takes effect at the next clk edge: outputs read 0 on the following cycle and state is IDLE.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with random inputs → `xpos`=`ypos`=0 throughout. After release with mouse (100,200), outputs read (100,200) one cycle later.
- Follow/clamp in IDLE: `mouse_ypos`=800 → `ypos`=704. `mouse_ypos`=4095 → 704. `mouse_ypos`=703 → 703.
- Fall profile (TICK_DIV=4): click at `ypos`=0, `xpos`=300. Required:
  - `ypos` after ticks 1..5 = 1, 3, 6, 10, 15.
  - Tick 37 → 703; tick 38 → 704 (saturated), state RISE, `v`=29.
  - Next tick `ypos`=676.
  - `xpos`=300 throughout.
- Settle: continue the run → `ypos` ends at 704, state REST, no further change for 1000 cycles. Click in REST → IDLE, and outputs follow mouse the next cycle.
- Ignored click: extra `mouse_left` pulses during FALL and RISE → trajectory identical to the undisturbed run. Holding `mouse_left` high from IDLE produces exactly one click.
- Reset mid-motion: assert `rst`=0 mid-RISE for one cycle → `xpos`=`ypos`=0 next cycle, IDLE follow resumes, and a fresh click reproduces the fall profile above.
